// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder sequencer. One external single-digit BCD
// adder is time-shared, least-significant digit first; the inter-digit
// carry is held in a flop between digit cycles. Operands with a digit
// above 9 are rejected without running any digit cycles.
//
// Handshake: start is a request that is sampled only in IDLE; an accepted
// request always produces exactly one done pulse (unless reset intervenes),
// and start seen in ADD or FIN is dropped, not queued. sum/cout/err are
// valid from the done cycle until the next accepted start.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [3:0]            dx,
  output logic [3:0]            dy,
  output logic                  cin,
  input  logic [3:0]            ds,
  input  logic                  dcarry,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            state_dbg
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic            op_bad;

  // True when any nibble of the packed value is not a decimal digit.
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign op_bad    = has_bad_digit(a) | has_bad_digit(b);
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: invalid operands skip straight to FIN.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = op_bad ? S_FIN : S_ADD;
      end
      S_ADD: begin
        if (cnt == LAST) state_nxt = S_FIN;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs; the adder inputs are parked at zero outside ADD.
  always_comb begin
    dx   = 4'd0;
    dy   = 4'd0;
    cin  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_ADD: begin
        dx   = a_sh[3:0];
        dy   = b_sh[3:0];
        cin  = carry;
        busy = 1'b1;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture at accept, one digit written per ADD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= op_bad;
          end
        end
        S_ADD: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cnt == CW'(i)) sum[4*i +: 4] <= ds;
          end
          carry <= dcarry;
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) cout <= dcarry;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for bcd_serial_add_ctrl with DIGITS=4. A behavioural single-digit
// BCD adder closes the loop; directed operations push hand-computed results
// into a queue and a negedge monitor pops and compares on every done pulse.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int EW     = W + 6;   // {busy_len[3:0], err, cout, sum}

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [3:0]    dx;
  logic [3:0]    dy;
  logic          cin;
  logic [3:0]    ds;
  logic          dcarry;
  logic [W-1:0]  sum;
  logic          cout;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    state_dbg;

  int            checks;
  int            errors;
  int            cyc;
  int            busy_cnt;
  logic [EW-1:0] exp_q[$];
  logic          exp_cin_q[$];
  int            done_cyc[$];

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .dx        (dx),
    .dy        (dy),
    .cin       (cin),
    .ds        (ds),
    .dcarry    (dcarry),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // External single-digit BCD adder.
  always_comb begin
    logic [4:0] t;
    t = {1'b0, dx} + {1'b0, dy} + {4'd0, cin};
    if (t > 5'd9) begin
      ds     = 4'(t - 5'd10);
      dcarry = 1'b1;
    end else begin
      ds     = t[3:0];
      dcarry = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
        if (exp_cin_q.size() > 0) check("cin_seq", {31'd0, cin}, {31'd0, exp_cin_q.pop_front()});
      end
      if (done) begin
        done_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("sum",      {16'd0, sum},      {16'd0, e[W-1:0]});
          check("cout",     {31'd0, cout},     {31'd0, e[W]});
          check("err",      {31'd0, err},      {31'd0, e[W+1]});
          check("busy_len", busy_cnt,          {28'd0, e[W+5:W+2]});
        end
        busy_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [W-1:0] s, input logic c, input logic e, input logic [3:0] bl);
    exp_q.push_back({bl, e, c, s});
  endtask

  // Wait (bounded) until every pushed expectation has been consumed.
  task automatic drain(output bit ok);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    ok = (exp_q.size() == 0);
    if (!ok) begin
      check("done_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  // One start pulse, expected result pushed, then latency check.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] es, input logic ec, input logic ee,
                        input logic [3:0] bl);
    int acc;
    bit ok;
    push_exp(es, ec, ee, bl);
    @(posedge clk); #1;
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    acc   = cyc;
    start = 1'b0;
    drain(ok);
    if (ok) check("latency", done_cyc[done_cyc.size()-1] - acc, {28'd0, bl});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    busy_cnt = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    check("rst_sum",   {16'd0, sum},       32'd0);
    check("rst_cout",  {31'd0, cout},      32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_done",  {31'd0, done},      32'd0);
    check("rst_err",   {31'd0, err},       32'd0);
    check("rst_cin",   {31'd0, cin},       32'd0);
    check("rst_dxdy",  {24'd0, dx, dy},    32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // 1234 + 5678 = 6912, carries into digits 1 and 2.
    exp_cin_q = '{1'b0, 1'b1, 1'b1, 1'b0};
    run_op(16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 4'd4);
    check("cin_q_used", exp_cin_q.size(), 32'd0);

    // Ripple carry through every digit.
    exp_cin_q = '{1'b0, 1'b1, 1'b1, 1'b1};
    run_op(16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 4'd4);
    run_op(16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0, 4'd4);

    // Non-BCD digit: error path, no ADD cycles, cleared result.
    run_op(16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 4'd0);
    run_op(16'h0003, 16'h0005, 16'h0008, 1'b0, 1'b0, 4'd4);
    run_op(16'h0001, 16'h00F0, 16'h0000, 1'b0, 1'b1, 4'd0);
    check("hold_err", {31'd0, err}, 32'd1);

    // Re-pulse during ADD with new operands is ignored.
    push_exp(16'h3333, 1'b0, 1'b0, 4'd4);
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 16'h5555; b = 16'h4444; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain(ok);
    repeat (3) @(posedge clk);
    #1;
    check("hold_sum", {16'd0, sum}, 32'h3333);

    // start held high: three back-to-back operations, period 6.
    done_cyc.delete();
    push_exp(16'h0003, 1'b0, 1'b0, 4'd4);
    push_exp(16'h0003, 1'b0, 1'b0, 4'd4);
    push_exp(16'h0003, 1'b0, 1'b0, 4'd4);
    @(posedge clk); #1;
    a = 16'h0001; b = 16'h0002; start = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    start = 1'b0;
    drain(ok);
    check("held_count", done_cyc.size(), 32'd3);
    if (done_cyc.size() == 3) begin
      check("held_period0", done_cyc[1] - done_cyc[0], 32'd6);
      check("held_period1", done_cyc[2] - done_cyc[1], 32'd6);
    end

    // Reset during the second ADD cycle of 4444 + 5555.
    @(posedge clk); #1;
    a = 16'h4444; b = 16'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", {30'd0, state_dbg}, 32'd0);
    check("mid_rst_sum",   {16'd0, sum},       32'd0);
    check("mid_rst_busy",  {31'd0, busy},      32'd0);
    check("mid_rst_cin",   {31'd0, cin},       32'd0);
    check("mid_rst_dxdy",  {24'd0, dx, dy},    32'd0);
    check("mid_rst_flags", {29'd0, done, err, cout}, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    run_op(16'h0004, 16'h0006, 16'h0010, 1'b0, 1'b0, 4'd4);

    repeat (4) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
